// File: rtl/clock_pkg.sv
// Shared widths, limits and state encoding for the time-of-day keeper.
package clock_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    UNSYNCED = 2'd0,
    REQUEST  = 2'd1,
    RUNNING  = 2'd2
  } clock_state_t;

  function automatic logic time_valid(input logic [HR_W-1:0]  h,
                                      input logic [MIN_W-1:0] m,
                                      input logic [SEC_W-1:0] s);
    return (h <= HR_MAX) && (m <= MIN_MAX) && (s <= SEC_MAX);
  endfunction

endpackage

// File: rtl/clock_core_tick_gen.sv
// Prescaler dividing clk down to a one-second tick; clear restarts the second.
module tick_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic wrap,
  output logic tick
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;

  // wrap lets the owner update time on the same edge that registers tick
  assign wrap = (presc == TC);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= wrap;
      if (clear || wrap) presc <= '0;
      else               presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/clock_core.sv
// Time-of-day keeper with host sync handshake. Periodic resync is built only
// when CLOCK_CORE_RESYNC_EN is defined; otherwise RUNNING is terminal.
//
// state    | meaning
// UNSYNCED | after reset or failed request; counting from whatever time is held
// REQUEST  | request=1, waiting for a valid host load or timeout
// RUNNING  | normal counting
module clock_core
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned RESYNC_S  = 3600,
  parameter int unsigned TIMEOUT_S = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [HR_W-1:0]  set_hr,
  input  logic [MIN_W-1:0] set_min,
  input  logic [SEC_W-1:0] set_sec,
  input  logic             set_done,
  output logic [HR_W-1:0]  hr,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic             request,
  output logic             tick,
  output logic             synced,
  output logic             load_err
);

  // One width serves both the timeout and resync counters
  localparam int unsigned CNT_MAX = (TIMEOUT_S > RESYNC_S) ? TIMEOUT_S : RESYNC_S;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  clock_state_t     state;
  logic [CNT_W-1:0] tcnt;
  logic             wrap;
  logic             load_ok;

  assign load_ok = set_done && time_valid(set_hr, set_min, set_sec);

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (load_ok),
    .wrap    (wrap),
    .tick    (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hr  <= '0;
      min <= '0;
      sec <= '0;
    end else if (load_ok) begin
      hr  <= set_hr;
      min <= set_min;
      sec <= set_sec;
    end else if (wrap) begin
      if (sec == SEC_MAX) begin
        sec <= '0;
        if (min == MIN_MAX) begin
          min <= '0;
          hr  <= (hr == HR_MAX) ? '0 : hr + 1'b1;
        end else begin
          min <= min + 1'b1;
        end
      end else begin
        sec <= sec + 1'b1;
      end
    end
  end

`ifdef CLOCK_CORE_RESYNC_EN
  logic [CNT_W-1:0] rcnt;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= UNSYNCED;
      request  <= 1'b0;
      synced   <= 1'b0;
      load_err <= 1'b0;
      tcnt     <= '0;
`ifdef CLOCK_CORE_RESYNC_EN
      rcnt     <= '0;
`endif
    end else if (load_ok) begin
      state    <= RUNNING;
      request  <= 1'b0;
      synced   <= 1'b1;
      load_err <= 1'b0;
      tcnt     <= '0;
`ifdef CLOCK_CORE_RESYNC_EN
      rcnt     <= '0;
`endif
    end else begin
      if (set_done) load_err <= 1'b1;
      case (state)
        UNSYNCED: begin
          state   <= REQUEST;
          request <= 1'b1;
          tcnt    <= '0;
        end
        REQUEST: begin
          if (wrap) begin
            if (tcnt == CNT_W'(TIMEOUT_S - 1)) begin
              request <= 1'b0;
              state   <= synced ? RUNNING : UNSYNCED;
`ifdef CLOCK_CORE_RESYNC_EN
              rcnt    <= '0;
`endif
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        RUNNING: begin
`ifdef CLOCK_CORE_RESYNC_EN
          if (wrap) begin
            if (rcnt == CNT_W'(RESYNC_S - 1)) begin
              state   <= REQUEST;
              request <= 1'b1;
              tcnt    <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
`else
          state <= RUNNING;
`endif
        end
        default: begin
          state   <= UNSYNCED;
          request <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_core.sv
// Directed bench for clock_core: table of load/tick vectors plus handshake sequences.
module tb_clock_core;
  import clock_pkg::*;

  localparam int unsigned CLK_HZ    = 10;
  localparam int unsigned RESYNC_S  = 3;
  localparam int unsigned TIMEOUT_S = 5;
  localparam int          BUDGET    = 40;

`ifdef CLOCK_CORE_RESYNC_EN
  localparam logic EXP_RESYNC_REQ = 1'b1;
`else
  localparam logic EXP_RESYNC_REQ = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [HR_W-1:0]  set_hr = '0;
  logic [MIN_W-1:0] set_min = '0;
  logic [SEC_W-1:0] set_sec = '0;
  logic             set_done = 1'b0;
  logic [HR_W-1:0]  hr;
  logic [MIN_W-1:0] min;
  logic [SEC_W-1:0] sec;
  logic             request, tick, synced, load_err;

  int errors = 0;
  int checks = 0;

  clock_core #(.CLK_HZ(CLK_HZ), .RESYNC_S(RESYNC_S), .TIMEOUT_S(TIMEOUT_S)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .set_hr   (set_hr),
    .set_min  (set_min),
    .set_sec  (set_sec),
    .set_done (set_done),
    .hr       (hr),
    .min      (min),
    .sec      (sec),
    .request  (request),
    .tick     (tick),
    .synced   (synced),
    .load_err (load_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    int         ticks;
    logic [4:0] eh;
    logic [5:0] em;
    logic [5:0] es;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_hr = h; set_min = m; set_sec = s; set_done = 1'b1;
    step();
    set_done = 1'b0;
  endtask

  task automatic wait_tick(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = -1;
    for (int i = 1; i <= BUDGET && !seen; i++) begin
      step();
      if (tick) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: no tick within %0d cycles", BUDGET);
    end
  endtask

  task automatic check_time(input string tag, input logic [4:0] h, input logic [5:0] m,
                            input logic [5:0] s);
    check({tag, "_hr"},  32'(hr),  32'(h));
    check({tag, "_min"}, 32'(min), 32'(m));
    check({tag, "_sec"}, 32'(sec), 32'(s));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cyc;
    int  ticks_seen;
    bit  fell;

    vecs[0] = '{5'd12, 6'd34, 6'd56, 0, 5'd12, 6'd34, 6'd56};
    vecs[1] = '{5'd23, 6'd59, 6'd59, 1, 5'd0,  6'd0,  6'd0};
    vecs[2] = '{5'd9,  6'd59, 6'd59, 1, 5'd10, 6'd0,  6'd0};
    vecs[3] = '{5'd0,  6'd0,  6'd59, 1, 5'd0,  6'd1,  6'd0};
    vecs[4] = '{5'd13, 6'd59, 6'd58, 2, 5'd14, 6'd0,  6'd0};
    vecs[5] = '{5'd5,  6'd6,  6'd7,  3, 5'd5,  6'd6,  6'd10};

    repeat (3) @(posedge clock);
    #1;
    check_time("rst", 5'd0, 6'd0, 6'd0);
    check("rst_request",  32'(request),  0);
    check("rst_tick",     32'(tick),     0);
    check("rst_synced",   32'(synced),   0);
    check("rst_load_err", 32'(load_err), 0);

    reset_n = 1'b1;
    check("req_1st_cycle", 32'(request), 0);
    step();
    check("req_2nd_cycle", 32'(request), 1);

    // No host answer: request should drop on the 5th tick, then re-rise
    ticks_seen = 0;
    fell       = 1'b0;
    for (int i = 0; i < 200 && !fell; i++) begin
      step();
      if (tick) ticks_seen++;
      if (!request) fell = 1'b1;
    end
    check("timeout_fell",   32'(fell),       1);
    check("timeout_ticks",  32'(ticks_seen), TIMEOUT_S);
    check("timeout_synced", 32'(synced),     0);
    check_time("unsynced_count", 5'd0, 6'd0, 6'd5);
    step();
    check("rerequest", 32'(request), 1);

    load(5'd24, 6'd0, 6'd0);
    check_time("bad_load", 5'd0, 6'd0, 6'd5);
    check("bad_load_err", 32'(load_err), 1);
    check("bad_load_req", 32'(request),  1);
    check("bad_load_syn", 32'(synced),   0);

    load(5'd1, 6'd2, 6'd3);
    check_time("good_load", 5'd1, 6'd2, 6'd3);
    check("good_load_err", 32'(load_err), 0);
    check("good_load_req", 32'(request),  0);
    check("good_load_syn", 32'(synced),   1);

    for (int v = 0; v < 6; v++) begin
      load(vecs[v].h, vecs[v].m, vecs[v].s);
      check_time($sformatf("v%0d_load", v), vecs[v].h, vecs[v].m, vecs[v].s);
      check($sformatf("v%0d_req", v), 32'(request), 0);
      for (int t = 0; t < vecs[v].ticks; t++) begin
        wait_tick(cyc);
        if (t == 0) check($sformatf("v%0d_first_tick", v), 32'(cyc), CLK_HZ);
      end
      check_time($sformatf("v%0d_after", v), vecs[v].eh, vecs[v].em, vecs[v].es);
    end

    // Load lands on the same edge as a tick: load values win, tick still pulses
    load(5'd20, 6'd0, 6'd0);
    repeat (CLK_HZ - 1) step();
    check("pre_coinc_tick", 32'(tick), 0);
    check_time("pre_coinc", 5'd20, 6'd0, 6'd0);
    set_hr = 5'd7; set_min = 6'd8; set_sec = 6'd9; set_done = 1'b1;
    step();
    set_done = 1'b0;
    check("coinc_tick", 32'(tick), 1);
    check_time("coinc", 5'd7, 6'd8, 6'd9);
    wait_tick(cyc);
    check("coinc_next_tick", 32'(cyc), CLK_HZ);
    check_time("coinc_next", 5'd7, 6'd8, 6'd10);

    // Periodic resync request at the 3rd tick only when the feature is built
    load(5'd0, 6'd0, 6'd0);
    wait_tick(cyc);
    check("resync_t1_req", 32'(request), 0);
    wait_tick(cyc);
    check("resync_t2_req", 32'(request), 0);
    wait_tick(cyc);
    check("resync_t3_req", 32'(request), 32'(EXP_RESYNC_REQ));
    load(5'd2, 6'd0, 6'd0);
    check("resync_load_req", 32'(request), 0);

    reset_n = 1'b0;
    #1;
    check("rst2_synced", 32'(synced), 0);
    check_time("rst2", 5'd0, 6'd0, 6'd0);
    step();
    reset_n = 1'b1;
    step();
    check("rst2_req", 32'(request), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_req_drop", 32'(request), 0);
    step();
    reset_n = 1'b1;
    step();
    check("restart_req", 32'(request), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
